trap_csr_ctrl: RTL and testbench

//   Machine-mode trap CSR controller. Sits directly downstream of the trap stage.
//   - Consumes TRAP_EN/PC/CODE/JMP_TO.
//   - Commits mepc/mcause/mstatus and raises a one-cycle pipeline FLUSH plus redirect.
//   - Handles MRET returns and software CSR access to mstatus/mtvec/mepc/mcause.
//   - Drives the vector mode/base and interrupt-allow signals back to the trap stage.

---
 rtl/trap_csr_ctrl.sv | 151 +++++++++++++++
 tb/tb_trap_csr_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/trap_csr_ctrl.sv
// Machine-mode trap CSR controller: commits trap state, handles MRET and
// software access to mstatus/mtvec/mepc/mcause, and issues a one-cycle flush/redirect.
module trap_csr_ctrl #(
   parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
   parameter bit          VECTORED_EN = 1'b1
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        MEM_WAIT,
   input  logic        TRAP_EN,
   input  logic [31:0] TRAP_PC,
   input  logic [31:0] TRAP_CODE,
   input  logic [31:0] TRAP_JMP_TO,
   input  logic        MRET_EN,
   input  logic        CSR_WE,
   input  logic [11:0] CSR_ADDR,
   input  logic [31:0] CSR_WDATA,
   output logic [31:0] CSR_RDATA,
   output logic [1:0]  TRAP_VEC_MODE,
   output logic [31:0] TRAP_VEC_BASE,
   output logic        INT_ALLOW,
   output logic        FLUSH,
   output logic        JMP_EN,
   output logic [31:0] JMP_TO
);

   localparam int unsigned XLEN   = 32;
   localparam int unsigned ADDR_W = 12;

   localparam logic [ADDR_W-1:0] ADDR_MSTATUS = 12'h300;
   localparam logic [ADDR_W-1:0] ADDR_MTVEC   = 12'h305;
   localparam logic [ADDR_W-1:0] ADDR_MEPC    = 12'h341;
   localparam logic [ADDR_W-1:0] ADDR_MCAUSE  = 12'h342;

   localparam logic [XLEN-1:0] WORD_MASK = ~XLEN'(3);

   typedef enum logic {
      S_IDLE,
      S_REDIRECT
   } state_t;

   state_t            state_q, state_d;
   logic              mie_q, mie_d;
   logic              mpie_q, mpie_d;
   logic [XLEN-3:0]   mtvec_base_q, mtvec_base_d;
   logic              mtvec_mode_q, mtvec_mode_d;
   logic [XLEN-1:0]   mepc_q, mepc_d;
   logic [XLEN-1:0]   mcause_q, mcause_d;
   logic              flush_q, flush_d;
   logic              jmp_en_q, jmp_en_d;
   logic [XLEN-1:0]   jmp_to_q, jmp_to_d;

   // State register; a stall freezes everything, reset overrides the stall
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q      <= S_IDLE;
         mie_q        <= 1'b0;
         mpie_q       <= 1'b0;
         mtvec_base_q <= MTVEC_RESET[XLEN-1:2];
         mtvec_mode_q <= 1'b0;
         mepc_q       <= '0;
         mcause_q     <= '0;
         flush_q      <= 1'b0;
         jmp_en_q     <= 1'b0;
         jmp_to_q     <= '0;
      end else if (!MEM_WAIT) begin
         state_q      <= state_d;
         mie_q        <= mie_d;
         mpie_q       <= mpie_d;
         mtvec_base_q <= mtvec_base_d;
         mtvec_mode_q <= mtvec_mode_d;
         mepc_q       <= mepc_d;
         mcause_q     <= mcause_d;
         flush_q      <= flush_d;
         jmp_en_q     <= jmp_en_d;
         jmp_to_q     <= jmp_to_d;
      end
   end

   // Next-state: trap beats MRET beats CSR write; REDIRECT ignores all requests
   always_comb begin
      state_d      = state_q;
      mie_d        = mie_q;
      mpie_d       = mpie_q;
      mtvec_base_d = mtvec_base_q;
      mtvec_mode_d = mtvec_mode_q;
      mepc_d       = mepc_q;
      mcause_d     = mcause_q;
      flush_d      = 1'b0;
      jmp_en_d     = 1'b0;
      jmp_to_d     = jmp_to_q;

      case (state_q)
         S_IDLE: begin
            if (TRAP_EN) begin
               state_d  = S_REDIRECT;
               mepc_d   = TRAP_PC & WORD_MASK;
               mcause_d = TRAP_CODE;
               mpie_d   = mie_q;
               mie_d    = 1'b0;
               flush_d  = 1'b1;
               jmp_en_d = 1'b1;
               jmp_to_d = TRAP_JMP_TO;
            end else if (MRET_EN) begin
               state_d  = S_REDIRECT;
               mie_d    = mpie_q;
               mpie_d   = 1'b1;
               flush_d  = 1'b1;
               jmp_en_d = 1'b1;
               jmp_to_d = mepc_q;
            end else if (CSR_WE) begin
               case (CSR_ADDR)
                  ADDR_MSTATUS: begin
                     mie_d  = CSR_WDATA[3];
                     mpie_d = CSR_WDATA[7];
                  end
                  ADDR_MTVEC: begin
                     mtvec_base_d = CSR_WDATA[XLEN-1:2];
                     mtvec_mode_d = VECTORED_EN && CSR_WDATA[0];
                  end
                  ADDR_MEPC:   mepc_d   = CSR_WDATA & WORD_MASK;
                  ADDR_MCAUSE: mcause_d = CSR_WDATA;
                  default: ;
               endcase
            end
         end
         S_REDIRECT: state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase
   end

   // Combinational CSR read; old value is visible until the write edge
   always_comb begin
      CSR_RDATA = '0;
      case (CSR_ADDR)
         ADDR_MSTATUS: CSR_RDATA = {19'd0, 2'b11, 3'd0, mpie_q, 3'd0, mie_q, 3'd0};
         ADDR_MTVEC:   CSR_RDATA = {mtvec_base_q, 1'b0, mtvec_mode_q};
         ADDR_MEPC:    CSR_RDATA = mepc_q;
         ADDR_MCAUSE:  CSR_RDATA = mcause_q;
         default:      CSR_RDATA = '0;
      endcase
   end

   assign TRAP_VEC_MODE = {1'b0, mtvec_mode_q};
   assign TRAP_VEC_BASE = {mtvec_base_q, 2'b00};
   assign INT_ALLOW     = mie_q;
   assign FLUSH         = flush_q;
   assign JMP_EN        = jmp_en_q;
   assign JMP_TO        = jmp_to_q;

endmodule

// File: tb/tb_trap_csr_ctrl.sv
// Self-checking bench for trap_csr_ctrl: directed vector table plus
// hand-written sequences for read-during-write, mtvec masking and reset in REDIRECT.
module tb_trap_csr_ctrl;

   logic        CLK = 1'b0;
   logic        RST;
   logic        MEM_WAIT;
   logic        TRAP_EN;
   logic [31:0] TRAP_PC;
   logic [31:0] TRAP_CODE;
   logic [31:0] TRAP_JMP_TO;
   logic        MRET_EN;
   logic        CSR_WE;
   logic [11:0] CSR_ADDR;
   logic [31:0] CSR_WDATA;

   logic [31:0] rdata, rdata0;
   logic [1:0]  vmode, vmode0;
   logic [31:0] vbase, vbase0;
   logic        allow, allow0;
   logic        flush, flush0;
   logic        jen, jen0;
   logic [31:0] jto, jto0;

   int passed = 0;
   int total  = 0;

   always #5 CLK = ~CLK;

   trap_csr_ctrl #(.MTVEC_RESET(32'h0000_0000), .VECTORED_EN(1'b1)) dut (
      .CLK(CLK), .RST(RST), .MEM_WAIT(MEM_WAIT), .TRAP_EN(TRAP_EN), .TRAP_PC(TRAP_PC),
      .TRAP_CODE(TRAP_CODE), .TRAP_JMP_TO(TRAP_JMP_TO), .MRET_EN(MRET_EN), .CSR_WE(CSR_WE),
      .CSR_ADDR(CSR_ADDR), .CSR_WDATA(CSR_WDATA), .CSR_RDATA(rdata), .TRAP_VEC_MODE(vmode),
      .TRAP_VEC_BASE(vbase), .INT_ALLOW(allow), .FLUSH(flush), .JMP_EN(jen), .JMP_TO(jto)
   );

   // Non-vectored instance with a misaligned reset vector
   trap_csr_ctrl #(.MTVEC_RESET(32'h0000_0803), .VECTORED_EN(1'b0)) dut0 (
      .CLK(CLK), .RST(RST), .MEM_WAIT(MEM_WAIT), .TRAP_EN(TRAP_EN), .TRAP_PC(TRAP_PC),
      .TRAP_CODE(TRAP_CODE), .TRAP_JMP_TO(TRAP_JMP_TO), .MRET_EN(MRET_EN), .CSR_WE(CSR_WE),
      .CSR_ADDR(CSR_ADDR), .CSR_WDATA(CSR_WDATA), .CSR_RDATA(rdata0), .TRAP_VEC_MODE(vmode0),
      .TRAP_VEC_BASE(vbase0), .INT_ALLOW(allow0), .FLUSH(flush0), .JMP_EN(jen0), .JMP_TO(jto0)
   );

   typedef struct {
      logic        te, mr, we, mw;
      logic [11:0] addr;
      logic [31:0] wdata, pc, code, jt;
      logic        e_flush, e_jen;
      logic [31:0] e_jto;
      logic [11:0] raddr;
      logic [31:0] e_rdata;
      logic        e_allow;
   } vec_t;

   localparam int NVEC = 24;
   vec_t vecs[NVEC];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   task automatic clear_strobes();
      TRAP_EN = 1'b0; MRET_EN = 1'b0; CSR_WE = 1'b0; MEM_WAIT = 1'b0;
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      //          te  mr  we  mw  addr    wdata          pc            code          jt            fl  je  jto           raddr   rdata         allow
      vecs[0]  = '{0, 0, 1, 0, 12'h305, 32'h0000_1001, 32'h0,        32'h0,        32'h0,        0, 0, 32'h0,        12'h305, 32'h0000_1001, 0};
      vecs[1]  = '{0, 0, 1, 0, 12'h300, 32'h0000_0008, 32'h0,        32'h0,        32'h0,        0, 0, 32'h0,        12'h300, 32'h0000_1808, 1};
      vecs[2]  = '{1, 0, 0, 0, 12'h341, 32'h0,         32'h0000_0200, 32'h0000_000B, 32'h0000_102C, 1, 1, 32'h0000_102C, 12'h341, 32'h0000_0200, 0};
      vecs[3]  = '{0, 0, 0, 0, 12'h342, 32'h0,         32'h0,        32'h0,        32'h0,        0, 0, 32'h0000_102C, 12'h342, 32'h0000_000B, 0};
      vecs[4]  = '{0, 0, 0, 0, 12'h300, 32'h0,         32'h0,        32'h0,        32'h0,        0, 0, 32'h0000_102C, 12'h300, 32'h0000_1880, 0};
      vecs[5]  = '{0, 1, 0, 0, 12'h300, 32'h0,         32'h0,        32'h0,        32'h0,        1, 1, 32'h0000_0200, 12'h300, 32'h0000_1888, 1};
      vecs[6]  = '{0, 0, 0, 0, 12'h300, 32'h0,         32'h0,        32'h0,        32'h0,        0, 0, 32'h0000_0200, 12'h300, 32'h0000_1888, 1};
      vecs[7]  = '{0, 0, 1, 0, 12'h341, 32'h0000_1237, 32'h0,        32'h0,        32'h0,        0, 0, 32'h0000_0200, 12'h341, 32'h0000_1234, 1};
      vecs[8]  = '{0, 0, 1, 0, 12'h342, 32'h8000_0007, 32'h0,        32'h0,        32'h0,        0, 0, 32'h0000_0200, 12'h342, 32'h8000_0007, 1};
      vecs[9]  = '{0, 0, 1, 0, 12'h340, 32'h0000_DEAD, 32'h0,        32'h0,        32'h0,        0, 0, 32'h0000_0200, 12'h340, 32'h0000_0000, 1};
      vecs[10] = '{1, 1, 1, 0, 12'h341, 32'hAAAA_AAA0, 32'h0000_0306, 32'h8000_000B, 32'h0000_104C, 1, 1, 32'h0000_104C, 12'h341, 32'h0000_0304, 0};
      vecs[11] = '{1, 0, 1, 0, 12'h342, 32'h0000_0077, 32'h0000_0999, 32'h0000_0005, 32'h0000_5000, 0, 0, 32'h0000_104C, 12'h342, 32'h8000_000B, 0};
      vecs[12] = '{0, 1, 1, 0, 12'h300, 32'h0000_0000, 32'h0,        32'h0,        32'h0,        1, 1, 32'h0000_0304, 12'h300, 32'h0000_1888, 1};
      vecs[13] = '{0, 0, 0, 0, 12'h300, 32'h0,         32'h0,        32'h0,        32'h0,        0, 0, 32'h0000_0304, 12'h300, 32'h0000_1888, 1};
      vecs[14] = '{0, 0, 1, 0, 12'h300, 32'h0000_0080, 32'h0,        32'h0,        32'h0,        0, 0, 32'h0000_0304, 12'h300, 32'h0000_1880, 0};
      vecs[15] = '{0, 1, 0, 0, 12'h300, 32'h0,         32'h0,        32'h0,        32'h0,        1, 1, 32'h0000_0304, 12'h300, 32'h0000_1888, 1};
      vecs[16] = '{0, 0, 0, 0, 12'h300, 32'h0,         32'h0,        32'h0,        32'h0,        0, 0, 32'h0000_0304, 12'h300, 32'h0000_1888, 1};
      vecs[17] = '{1, 0, 0, 0, 12'h341, 32'h0,         32'h0000_0400, 32'h0000_0003, 32'h0000_2000, 1, 1, 32'h0000_2000, 12'h341, 32'h0000_0400, 0};
      vecs[18] = '{1, 0, 0, 1, 12'h342, 32'h0,         32'h0000_0800, 32'h0000_0009, 32'h0000_3000, 1, 1, 32'h0000_2000, 12'h342, 32'h0000_0003, 0};
      vecs[19] = '{1, 0, 0, 1, 12'h342, 32'h0,         32'h0000_0800, 32'h0000_0009, 32'h0000_3000, 1, 1, 32'h0000_2000, 12'h342, 32'h0000_0003, 0};
      vecs[20] = '{1, 0, 0, 1, 12'h341, 32'h0,         32'h0000_0800, 32'h0000_0009, 32'h0000_3000, 1, 1, 32'h0000_2000, 12'h341, 32'h0000_0400, 0};
      vecs[21] = '{1, 0, 0, 0, 12'h341, 32'h0,         32'h0000_0800, 32'h0000_0009, 32'h0000_3000, 0, 0, 32'h0000_2000, 12'h341, 32'h0000_0400, 0};
      vecs[22] = '{0, 0, 1, 1, 12'h305, 32'h0000_0000, 32'h0,        32'h0,        32'h0,        0, 0, 32'h0000_2000, 12'h305, 32'h0000_1001, 0};
      vecs[23] = '{0, 0, 1, 0, 12'h305, 32'h0000_2003, 32'h0,        32'h0,        32'h0,        0, 0, 32'h0000_2000, 12'h305, 32'h0000_2001, 0};

      clear_strobes();
      TRAP_PC = '0; TRAP_CODE = '0; TRAP_JMP_TO = '0;
      CSR_ADDR = '0; CSR_WDATA = '0;
      RST = 1'b1;
      tick();
      tick();
      RST = 1'b0;

      // Reset state
      check("rst_flush", 32'(flush), 32'd0);
      check("rst_jmp_en", 32'(jen), 32'd0);
      check("rst_jmp_to", jto, 32'h0);
      check("rst_int_allow", 32'(allow), 32'd0);
      CSR_ADDR = 12'h300; #1;
      check("rst_mstatus", rdata, 32'h0000_1800);
      CSR_ADDR = 12'h305; #1;
      check("rst_mtvec", rdata, 32'h0);
      check("rst_mtvec_masked_nv", rdata0, 32'h0000_0800);
      CSR_ADDR = 12'h341; #1;
      check("rst_mepc", rdata, 32'h0);
      CSR_ADDR = 12'h342; #1;
      check("rst_mcause", rdata, 32'h0);

      // Directed vector table
      for (int i = 0; i < NVEC; i++) begin
         TRAP_EN = vecs[i].te; MRET_EN = vecs[i].mr; CSR_WE = vecs[i].we;
         MEM_WAIT = vecs[i].mw; CSR_ADDR = vecs[i].addr; CSR_WDATA = vecs[i].wdata;
         TRAP_PC = vecs[i].pc; TRAP_CODE = vecs[i].code; TRAP_JMP_TO = vecs[i].jt;
         tick();
         clear_strobes();
         CSR_ADDR = vecs[i].raddr;
         #1;
         check($sformatf("v%0d_flush", i), 32'(flush), 32'(vecs[i].e_flush));
         check($sformatf("v%0d_jmp_en", i), 32'(jen), 32'(vecs[i].e_jen));
         check($sformatf("v%0d_jmp_to", i), jto, vecs[i].e_jto);
         check($sformatf("v%0d_rdata", i), rdata, vecs[i].e_rdata);
         check($sformatf("v%0d_int_allow", i), 32'(allow), 32'(vecs[i].e_allow));
      end
      check("vec_base", vbase, 32'h0000_2000);
      check("vec_mode", 32'(vmode), 32'd1);

      // Read-during-write shows old value until the edge
      CSR_WE = 1'b1; CSR_ADDR = 12'h342; CSR_WDATA = 32'h0000_0055;
      #1;
      check("rdw_old", rdata, 32'h0000_0003);
      tick();
      CSR_WE = 1'b0; #1;
      check("rdw_new", rdata, 32'h0000_0055);

      // mtvec low bits: MODE writable only when vectored
      CSR_WE = 1'b1; CSR_ADDR = 12'h305; CSR_WDATA = 32'h0000_0003;
      tick();
      CSR_WE = 1'b0; #1;
      check("mtvec3_vect", rdata, 32'h0000_0001);
      check("mtvec3_nonvect", rdata0, 32'h0000_0000);
      check("vmode_vect", 32'(vmode), 32'd1);
      check("vmode_nonvect", 32'(vmode0), 32'd0);
      check("vbase_zero", vbase, 32'h0);

      // Reset while in REDIRECT
      TRAP_EN = 1'b1; TRAP_PC = 32'h0000_0600; TRAP_CODE = 32'h2; TRAP_JMP_TO = 32'h0000_7000;
      tick();
      TRAP_EN = 1'b0; #1;
      check("pre_rst_flush", 32'(flush), 32'd1);
      RST = 1'b1;
      tick();
      RST = 1'b0;
      CSR_ADDR = 12'h341; #1;
      check("rst_redir_flush", 32'(flush), 32'd0);
      check("rst_redir_jmp_en", 32'(jen), 32'd0);
      check("rst_redir_jmp_to", jto, 32'h0);
      check("rst_redir_mepc", rdata, 32'h0);
      tick();
      check("post_rst_idle_flush", 32'(flush), 32'd0);
      // FSM back in IDLE: a new trap redirects with one-cycle latency
      TRAP_EN = 1'b1; TRAP_PC = 32'h0000_0704; TRAP_CODE = 32'h1; TRAP_JMP_TO = 32'h0000_8000;
      tick();
      TRAP_EN = 1'b0; #1;
      check("post_rst_trap_flush", 32'(flush), 32'd1);
      check("post_rst_trap_jmp_to", jto, 32'h0000_8000);
      check("post_rst_trap_mepc", rdata, 32'h0000_0704);
      tick();
      check("post_rst_trap_drop", 32'(flush), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
